hsid_mse_comp: RTL and testbench

//  Sits directly downstream of the MSE stage. Consumes one MSE result per library vector
//  and tracks min and max MSE with their library references over one search. Overflowed results
//  are counted but excluded from the comparison. Completion is flagged once the programmed

---
 rtl/hsid_mse_comp_if.sv | 36 +++
 rtl/hsid_mse_comp.sv | 140 ++++++++++++++
 tb/tb_hsid_mse_comp.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hsid_mse_comp_if.sv
// Bundle of search-control, MSE beat and result signals between the MSE stage
// and the min/max comparator.
interface hsid_mse_comp_if #(
  parameter int WORD_WIDTH        = 16,
  parameter int HSP_LIBRARY_WIDTH = 8
);
  logic                         clear;
  logic                         start;
  logic [HSP_LIBRARY_WIDTH-1:0] hsi_library_size;
  logic [WORD_WIDTH-1:0]        mse_value;
  logic [HSP_LIBRARY_WIDTH-1:0] mse_ref;
  logic                         mse_valid;
  logic                         mse_of;

  logic [WORD_WIDTH-1:0]        min_mse_value;
  logic [HSP_LIBRARY_WIDTH-1:0] min_mse_ref;
  logic [WORD_WIDTH-1:0]        max_mse_value;
  logic [HSP_LIBRARY_WIDTH-1:0] max_mse_ref;
  logic                         found;
  logic [HSP_LIBRARY_WIDTH-1:0] of_count;
  logic                         busy;
  logic                         done;
  logic                         error;

  modport master (
    output clear, start, hsi_library_size, mse_value, mse_ref, mse_valid, mse_of,
    input  min_mse_value, min_mse_ref, max_mse_value, max_mse_ref,
    input  found, of_count, busy, done, error
  );

  modport slave (
    input  clear, start, hsi_library_size, mse_value, mse_ref, mse_valid, mse_of,
    output min_mse_value, min_mse_ref, max_mse_value, max_mse_ref,
    output found, of_count, busy, done, error
  );
endinterface

// File: rtl/hsid_mse_comp.sv
// Tracks min/max MSE and their library refs over one search; overflowed
// results are counted and excluded. Completion after the programmed count.
//
// state  | meaning
// S_IDLE | no search active; beats flag error
// S_RUN  | accepting beats until size results have arrived
// S_DONE | results frozen until start or clear; beats flag error
module hsid_mse_comp #(
  parameter int WORD_WIDTH        = 16,
  parameter int HSP_LIBRARY_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  hsid_mse_comp_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [HSP_LIBRARY_WIDTH-1:0] ONE_L = HSP_LIBRARY_WIDTH'(1);

  state_t                       r_state, w_state_nxt;
  logic [HSP_LIBRARY_WIDTH-1:0] r_size, w_size_nxt;
  logic [HSP_LIBRARY_WIDTH-1:0] r_count, w_count_nxt;
  logic [HSP_LIBRARY_WIDTH-1:0] r_of_count, w_of_count_nxt;
  logic [WORD_WIDTH-1:0]        r_min, w_min_nxt;
  logic [WORD_WIDTH-1:0]        r_max, w_max_nxt;
  logic [HSP_LIBRARY_WIDTH-1:0] r_min_ref, w_min_ref_nxt;
  logic [HSP_LIBRARY_WIDTH-1:0] r_max_ref, w_max_ref_nxt;
  logic                         r_found, w_found_nxt;
  logic                         r_error, w_error_nxt;
  logic                         r_busy, r_done;
  logic                         w_beat;
  logic [HSP_LIBRARY_WIDTH-1:0] w_size_m1;

  assign w_beat    = bus.mse_valid | bus.mse_of;
  assign w_size_m1 = r_size - ONE_L;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_size_nxt     = r_size;
    w_count_nxt    = r_count;
    w_of_count_nxt = r_of_count;
    w_min_nxt      = r_min;
    w_max_nxt      = r_max;
    w_min_ref_nxt  = r_min_ref;
    w_max_ref_nxt  = r_max_ref;
    w_found_nxt    = r_found;
    w_error_nxt    = r_error;

    if (bus.clear) begin
      w_state_nxt    = S_IDLE;
      w_size_nxt     = '0;
      w_count_nxt    = '0;
      w_of_count_nxt = '0;
      w_min_nxt      = '1;
      w_max_nxt      = '0;
      w_min_ref_nxt  = '0;
      w_max_ref_nxt  = '0;
      w_found_nxt    = 1'b0;
      w_error_nxt    = 1'b0;
    end else if (bus.start) begin
      // a beat coinciding with start belongs to no search and is dropped
      w_state_nxt    = (bus.hsi_library_size == '0) ? S_DONE : S_RUN;
      w_size_nxt     = bus.hsi_library_size;
      w_count_nxt    = '0;
      w_of_count_nxt = '0;
      w_min_nxt      = '1;
      w_max_nxt      = '0;
      w_min_ref_nxt  = '0;
      w_max_ref_nxt  = '0;
      w_found_nxt    = 1'b0;
      w_error_nxt    = 1'b0;
    end else if (w_beat) begin
      if (r_state == S_RUN) begin
        w_count_nxt = r_count + ONE_L;
        if (bus.mse_of) begin
          w_of_count_nxt = r_of_count + ONE_L;
        end else begin
          w_found_nxt = 1'b1;
          // first valid beat seeds both extremes regardless of the init values
          if (!r_found || (bus.mse_value < r_min)) begin
            w_min_nxt     = bus.mse_value;
            w_min_ref_nxt = bus.mse_ref;
          end
          if (!r_found || (bus.mse_value > r_max)) begin
            w_max_nxt     = bus.mse_value;
            w_max_ref_nxt = bus.mse_ref;
          end
        end
        if (r_count == w_size_m1) w_state_nxt = S_DONE;
      end else begin
        w_error_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size     <= '0;
      r_count    <= '0;
      r_of_count <= '0;
      r_min      <= '1;
      r_max      <= '0;
      r_min_ref  <= '0;
      r_max_ref  <= '0;
      r_found    <= 1'b0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_size     <= w_size_nxt;
      r_count    <= w_count_nxt;
      r_of_count <= w_of_count_nxt;
      r_min      <= w_min_nxt;
      r_max      <= w_max_nxt;
      r_min_ref  <= w_min_ref_nxt;
      r_max_ref  <= w_max_ref_nxt;
      r_found    <= w_found_nxt;
      r_error    <= w_error_nxt;
      r_busy     <= (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.min_mse_value = r_min;
  assign bus.min_mse_ref   = r_min_ref;
  assign bus.max_mse_value = r_max;
  assign bus.max_mse_ref   = r_max_ref;
  assign bus.found         = r_found;
  assign bus.of_count      = r_of_count;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.error         = r_error;

endmodule

// File: tb/tb_hsid_mse_comp.sv
// Bench for hsid_mse_comp: directed searches checked every cycle against a
// list-based model, plus hand-computed literal checks.
module tb_hsid_mse_comp;
  localparam int WW = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hsid_mse_comp_if #(.WORD_WIDTH(WW), .HSP_LIBRARY_WIDTH(LW)) bus ();

  hsid_mse_comp #(.WORD_WIDTH(WW), .HSP_LIBRARY_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 run, 2 done; valid results kept in arrival order
  typedef struct packed {
    logic [WW-1:0] v;
    logic [LW-1:0] r;
  } res_t;
  res_t m_q[$];
  int   m_phase = 0;
  int   m_size  = 0;
  int   m_cnt   = 0;
  int   m_of    = 0;
  bit   m_err   = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_phase = 0; m_size = 0; m_cnt = 0; m_of = 0; m_err = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else if (bus.clear) model_reset();
      else if (bus.start) begin
        model_reset();
        m_size  = int'(bus.hsi_library_size);
        m_phase = (m_size == 0) ? 2 : 1;
      end else if (bus.mse_valid || bus.mse_of) begin
        if (m_phase == 1) begin
          m_cnt++;
          if (bus.mse_of) m_of++;
          else m_q.push_back('{v: bus.mse_value, r: bus.mse_ref});
          if (m_cnt == m_size) m_phase = 2;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [WW-1:0] emin, emax;
    logic [LW-1:0] eminr, emaxr;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        emin = '1; emax = '0; eminr = '0; emaxr = '0;
        foreach (m_q[i]) begin
          if (i == 0 || m_q[i].v < emin) begin emin = m_q[i].v; eminr = m_q[i].r; end
          if (i == 0 || m_q[i].v > emax) begin emax = m_q[i].v; emaxr = m_q[i].r; end
        end
        chk("min_val", 32'(bus.min_mse_value), 32'(emin));
        chk("min_ref", 32'(bus.min_mse_ref), 32'(eminr));
        chk("max_val", 32'(bus.max_mse_value), 32'(emax));
        chk("max_ref", 32'(bus.max_mse_ref), 32'(emaxr));
        chk("found", 32'(bus.found), 32'(m_q.size() > 0));
        chk("of_count", 32'(bus.of_count), 32'(m_of));
        chk("busy", 32'(bus.busy), 32'(m_phase == 1));
        chk("done", 32'(bus.done), 32'(m_phase == 2));
        chk("error", 32'(bus.error), 32'(m_err));
      end
    end
  end

  task automatic cyc(input bit clr, input bit st, input int sz,
                     input bit vld, input bit of, input int val, input int rf);
    @(negedge clk);
    bus.clear            = clr;
    bus.start            = st;
    bus.hsi_library_size = LW'(sz);
    bus.mse_valid        = vld;
    bus.mse_of           = of;
    bus.mse_value        = WW'(val);
    bus.mse_ref          = LW'(rf);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input int rf, input int val);
    cyc(0, 0, 0, 1, 0, val, rf);
  endtask

  task automatic ofb(input int rf);
    cyc(0, 0, 0, 0, 1, 0, rf);
  endtask

  task automatic go(input int sz);
    cyc(0, 1, sz, 0, 0, 0, 0);
  endtask

  initial begin
    bus.clear = 0; bus.start = 0; bus.hsi_library_size = '0;
    bus.mse_valid = 0; bus.mse_of = 0; bus.mse_value = '0; bus.mse_ref = '0;
    repeat (2) @(negedge clk);
    chk("rst_min", 32'(bus.min_mse_value), 32'hffff);
    chk("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle();

    // 1: tie on 20 keeps ref 1
    go(4); beat(0, 50); beat(1, 20); beat(2, 90);
    beat(3, 20);
    chk("t1_done_before", 32'(bus.done), 0);
    idle();
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_min", 32'(bus.min_mse_value), 20);
    chk("t1_minref", 32'(bus.min_mse_ref), 1);
    chk("t1_max", 32'(bus.max_mse_value), 90);
    chk("t1_maxref", 32'(bus.max_mse_ref), 2);
    chk("t1_of", 32'(bus.of_count), 0);
    idle();

    // 2
    go(3); ofb(0); beat(1, 7); ofb(2); idle();
    chk("t2_min", 32'(bus.min_mse_value), 7);
    chk("t2_maxref", 32'(bus.max_mse_ref), 1);
    chk("t2_of", 32'(bus.of_count), 2);
    chk("t2_done", 32'(bus.done), 1);

    // 3
    go(2); ofb(0); ofb(1); idle();
    chk("t3_found", 32'(bus.found), 0);
    chk("t3_min", 32'(bus.min_mse_value), 32'hffff);
    chk("t3_max", 32'(bus.max_mse_value), 0);
    chk("t3_of", 32'(bus.of_count), 2);

    // 4: empty search, then stray beat
    go(0); idle();
    chk("t4_done", 32'(bus.done), 1);
    chk("t4_busy", 32'(bus.busy), 0);
    beat(5, 3); idle();
    chk("t4_err", 32'(bus.error), 1);
    chk("t4_found", 32'(bus.found), 0);

    // 5: restart drops the coincident beat
    go(5); beat(0, 10); beat(1, 5);
    cyc(0, 1, 2, 1, 0, 1, 2);
    beat(7, 40); beat(8, 30); idle();
    chk("t5_done", 32'(bus.done), 1);
    chk("t5_min", 32'(bus.min_mse_value), 30);
    chk("t5_minref", 32'(bus.min_mse_ref), 8);
    chk("t5_maxref", 32'(bus.max_mse_ref), 7);
    chk("t5_err", 32'(bus.error), 0);

    // 6a: clear mid-run
    go(4); beat(0, 9); ofb(1);
    cyc(1, 0, 0, 0, 0, 0, 0); idle();
    chk("t6_clr_busy", 32'(bus.busy), 0);
    chk("t6_clr_of", 32'(bus.of_count), 0);
    chk("t6_clr_min", 32'(bus.min_mse_value), 32'hffff);

    // 6b: async reset between edges
    go(4); beat(0, 9); ofb(1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_found", 32'(bus.found), 0);
    chk("t6_rst_of", 32'(bus.of_count), 0);
    chk("t6_rst_max", 32'(bus.max_mse_value), 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(2, 4); idle();
    chk("t6_inflight_err", 32'(bus.error), 1);

    // 6c: clear wins over start
    cyc(1, 1, 3, 0, 0, 0, 0); idle();
    chk("t6_cs_busy", 32'(bus.busy), 0);
    chk("t6_cs_done", 32'(bus.done), 0);

    // extremes: all-ones and zero values
    go(3); beat(4, 65535); beat(5, 0); beat(6, 65535); idle();
    chk("ext_minref", 32'(bus.min_mse_ref), 5);
    chk("ext_maxref", 32'(bus.max_mse_ref), 4);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
